// File: rtl/xor_decrypt_rx.sv
// Serial repeating-key XOR decryptor: loads a key and a ciphertext frame MSB first, then streams plaintext.
// Optional short-frame flag on oFrame_error is built in when XOR_DECRYPT_FRAME_ERR_EN is defined.

// state | meaning
// IDLE  | waiting for iKey_flag (priority) or a fresh iCt_flag rising edge
// KEY   | shifting key bits in, up to KEY_SIZE bits or until iKey_flag drops
// RX    | shifting ciphertext bits in, MSB first
// TX    | driving plaintext bits out on oData_out with oData_flag high

module xor_decrypt_rx #(
  parameter int MSG_SIZE = 64,
  parameter int KEY_SIZE = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic iData_in,
  input  logic iKey_flag,
  input  logic iCt_flag,
  output logic oData_out,
  output logic oData_flag,
  output logic oBusy,
  output logic oFrame_error
);

  localparam int CW = $clog2(MSG_SIZE) + 1;

`ifdef XOR_DECRYPT_FRAME_ERR_EN
  localparam bit FERR_EN = 1'b1;
`else
  localparam bit FERR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, KEY, RX, TX} state_t;

  state_t              state_q;
  logic [KEY_SIZE-1:0] key_q;
  logic [KEY_SIZE-1:0] key_d;
  logic [MSG_SIZE-1:0] ct_q;
  logic [MSG_SIZE-1:0] ct_d;
  logic [MSG_SIZE-1:0] pt_q;
  logic [MSG_SIZE-1:0] pt_d;
  logic [CW-1:0]       cnt_q;
  logic                ct_arm_q;
  logic                data_q;
  logic                flag_q;
  logic                busy_q;
  logic                ferr_q;

  assign key_d = (key_q << 1) | KEY_SIZE'(iData_in);
  assign ct_d  = (ct_q << 1) | MSG_SIZE'(iData_in);
  // Key replication lines key bit (i mod KEY_SIZE) up with ciphertext bit i.
  assign pt_d  = ct_d ^ {(MSG_SIZE/KEY_SIZE){key_q}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      key_q    <= '0;
      ct_q     <= '0;
      pt_q     <= '0;
      cnt_q    <= '0;
      ct_arm_q <= 1'b1;
      data_q   <= 1'b0;
      flag_q   <= 1'b0;
      busy_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else if (ena) begin
      // A new frame needs iCt_flag to have been seen low since the last RX entry.
      if (!iCt_flag) ct_arm_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (iKey_flag) begin
            key_q   <= key_d;
            cnt_q   <= CW'(1);
            state_q <= (KEY_SIZE == 1) ? IDLE : KEY;
          end else if (iCt_flag && ct_arm_q) begin
            ct_q     <= ct_d;
            cnt_q    <= CW'(1);
            ct_arm_q <= 1'b0;
            ferr_q   <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= RX;
          end
        end
        KEY: begin
          if (!iKey_flag) begin
            state_q <= IDLE;
          end else begin
            key_q <= key_d;
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CW'(KEY_SIZE - 1)) state_q <= IDLE;
          end
        end
        RX: begin
          if (!iCt_flag) begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            ferr_q  <= FERR_EN;
            state_q <= IDLE;
          end else if (cnt_q == CW'(MSG_SIZE - 1)) begin
            ct_q    <= ct_d;
            pt_q    <= pt_d << 1;
            data_q  <= pt_d[MSG_SIZE-1];
            flag_q  <= 1'b1;
            cnt_q   <= CW'(1);
            state_q <= TX;
          end else begin
            ct_q  <= ct_d;
            cnt_q <= cnt_q + CW'(1);
          end
        end
        TX: begin
          if (cnt_q == CW'(MSG_SIZE)) begin
            data_q  <= 1'b0;
            flag_q  <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            data_q <= pt_q[MSG_SIZE-1];
            pt_q   <= pt_q << 1;
            cnt_q  <= cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign oData_out    = data_q;
  assign oData_flag   = flag_q;
  assign oBusy        = busy_q;
  assign oFrame_error = ferr_q;

endmodule

// File: tb/tb_xor_decrypt_rx.sv
// Scoreboard bench for xor_decrypt_rx: stimulus pushes expected plaintext frames,
// a negedge monitor reassembles oData_out bursts and compares them.

module tb_xor_decrypt_rx;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic ena = 1'b0;
  logic iData_in = 1'b0;
  logic iKey_flag = 1'b0;
  logic iCt_flag = 1'b0;
  logic oData_out;
  logic oData_flag;
  logic oBusy;
  logic oFrame_error;

`ifdef XOR_DECRYPT_FRAME_ERR_EN
  localparam bit FERR = 1'b1;
`else
  localparam bit FERR = 1'b0;
`endif

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];

  xor_decrypt_rx #(.MSG_SIZE(64), .KEY_SIZE(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .iData_in     (iData_in),
    .iKey_flag    (iKey_flag),
    .iCt_flag     (iCt_flag),
    .oData_out    (oData_out),
    .oData_flag   (oData_flag),
    .oBusy        (oBusy),
    .oFrame_error (oFrame_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a bit counts only on cycles where ena is high, so frozen cycles are not duplicated.
  int nb = 0;
  logic [63:0] sh = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      nb = 0;
    end else if (oData_flag) begin
      chk("busy_in_tx", 64'(oBusy), 64'd1);
      if (ena) begin
        sh = {sh[62:0], oData_out};
        nb++;
        if (nb == 64) begin
          nb = 0;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_burst: got %h expected no burst", sh);
          end else begin
            chk("burst_data", sh, exp_q.pop_front());
          end
        end
      end
    end else begin
      if (nb != 0) begin
        chk("burst_len", 64'(nb), 64'd64);
        nb = 0;
      end
      chk("out_zero_idle", 64'(oData_out), 64'd0);
    end
  end

  task automatic load_key(input logic [7:0] k, input int n);
    iKey_flag = 1'b1;
    for (int i = 0; i < n; i++) begin
      iData_in = k[n-1-i];
      tick();
    end
    iKey_flag = 1'b0;
    iData_in  = 1'b0;
    tick();
  endtask

  task automatic send_ct(input logic [63:0] ct, input int nbits, input int hold,
                         input int frz_at, input bit push, input logic [63:0] exp);
    if (push) exp_q.push_back(exp);
    iCt_flag = 1'b1;
    for (int i = 0; i < nbits; i++) begin
      if (i == frz_at) begin
        ena = 1'b0;
        repeat (5) tick();
        ena = 1'b1;
      end
      iData_in = ct[63-i];
      tick();
      if (i == 0) chk("ferr_clear_on_rx", 64'(oFrame_error), 64'd0);
    end
    if (nbits == 64) begin
      chk("latency_flag", 64'(oData_flag), 64'd1);
      chk("latency_busy", 64'(oBusy), 64'd1);
    end
    repeat (hold) tick();
    if (hold > 70) chk("no_restart", 64'(oBusy), 64'd0);
    iCt_flag = 1'b0;
    iData_in = 1'b0;
    tick();
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((oBusy || oData_flag) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: got busy after %0d cycles expected idle", n);
    end
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst_n = 1'b0;
    #2;
    chk("rst_data", 64'(oData_out), 64'd0);
    chk("rst_flag", 64'(oData_flag), 64'd0);
    chk("rst_busy", 64'(oBusy), 64'd0);
    chk("rst_ferr", 64'(oFrame_error), 64'd0);
    tick();
    rst_n = 1'b1;
    ena   = 1'b1;
    tick();

    // Basic frame with key 0xA5
    load_key(8'hA5, 8);
    send_ct(64'h0123456789ABCDEF, 64, 0, -1, 1'b1, 64'hA486E0C22C0E684A);
    wait_idle();

    // Zero key passes ciphertext through
    load_key(8'h00, 8);
    send_ct(64'hFFFF0000DEADBEEF, 64, 0, -1, 1'b1, 64'hFFFF0000DEADBEEF);
    wait_idle();

    // Short frame then recovery with key 0x3C
    load_key(8'h3C, 8);
    send_ct(64'h0123456789ABCDEF, 40, 0, -1, 1'b0, 64'h0);
    chk("short_busy", 64'(oBusy), 64'd0);
    chk("short_flag", 64'(oData_flag), 64'd0);
    chk("short_ferr", 64'(oFrame_error), 64'(FERR));
    tick();
    send_ct(64'h0123456789ABCDEF, 64, 0, -1, 1'b1, 64'h3D1F795BB597F1D3);
    wait_idle();

    // ena freeze in RX and in TX
    load_key(8'hA5, 8);
    send_ct(64'h0123456789ABCDEF, 64, 0, 30, 1'b1, 64'hA486E0C22C0E684A);
    repeat (30) tick();
    ena = 1'b0;
    repeat (5) tick();
    ena = 1'b1;
    wait_idle();

    // Partial key: 0xA5 shifted by four 1-bits gives 0x5F
    load_key(8'h0F, 4);
    send_ct(64'h0, 64, 0, -1, 1'b1, 64'h5F5F5F5F5F5F5F5F);
    wait_idle();

    // iCt_flag held high beyond the frame
    load_key(8'hA5, 8);
    send_ct(64'h0123456789ABCDEF, 64, 6, -1, 1'b1, 64'hA486E0C22C0E684A);
    wait_idle();
    send_ct(64'h0123456789ABCDEF, 64, 76, -1, 1'b1, 64'hA486E0C22C0E684A);
    wait_idle();
    send_ct(64'h0, 64, 0, -1, 1'b1, 64'hA5A5A5A5A5A5A5A5);
    wait_idle();

    // Reset partway through TX, then key must be zero
    send_ct(64'h0123456789ABCDEF, 64, 0, -1, 1'b0, 64'h0);
    repeat (19) tick();
    #1 rst_n = 1'b0;
    #1;
    chk("midtx_rst_data", 64'(oData_out), 64'd0);
    chk("midtx_rst_flag", 64'(oData_flag), 64'd0);
    chk("midtx_rst_busy", 64'(oBusy), 64'd0);
    chk("midtx_rst_ferr", 64'(oFrame_error), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    send_ct(64'hFFFF0000DEADBEEF, 64, 0, -1, 1'b1, 64'hFFFF0000DEADBEEF);
    wait_idle();

    repeat (3) tick();
    chk("all_bursts_seen", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
